// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Sequences one 32-bit load/store from the MEM stage into two half-word
//   accesses on an external 16-bit asynchronous SRAM. The low half goes first,
//   then the high half. Each access lasts WAIT_CYCLES+1 clocks. ready drops
//   for the whole transaction so the pipeline freezes around it.
//
// Parameters
//   SRAM_AW      SRAM half-word address width
//   WAIT_CYCLES  extra hold cycles per half-word access
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   MEM_R_EN, MEM_W_EN    load / store request, held until ready=1
//   addr, wdata           byte address and store data
//   rdata                 load data, valid when ready closes a read
//   ready                 no transaction pending, or one completes this cycle
//   SRAM_ADDR, SRAM_WE_N  SRAM half-word address and write strobe (active low)
//   sram_dq_out           write data toward the pad
//   sram_dq_oe            pad drive enable
//   sram_dq_in            read data from the pad
//   rd_count, wr_count    saturating transaction counters (SRAM_CTRL_STATS_EN only)
//
// Build option
//   SRAM_CTRL_STATS_EN    adds rd_count / wr_count outputs
//
// state  | meaning
// S_IDLE | no transaction; a request is accepted here
// S_LO   | low half-word access (addr bit 0 = 0, wdata[15:0])
// S_HI   | high half-word access (addr bit 0 = 1, wdata[31:16])
// S_DONE | one-cycle completion, ready=1
module sram_mem_controller #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  localparam int WW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;

  logic               req;
  logic               wr_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wd_q;

  // Transaction attributes for the cycle being set up: taken live from the
  // MEM stage on the accept cycle, from the captured copy afterwards.
  logic               wr_src;
  logic [SRAM_AW-2:0] word_src;
  logic [31:0]        wd_src;

  logic act_nxt;
  logic hi_nxt;
  logic last_nxt;
  logic last_now;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:SRAM_AW+1], addr[1:0]};

  assign req = MEM_R_EN | MEM_W_EN;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = '0;
    unique case (state)
      S_IDLE:  if (req) state_nxt = S_LO;
      S_LO:    if (wcnt == WLAST) state_nxt = S_HI;
      S_HI:    if (wcnt == WLAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if ((state_nxt == state) && ((state == S_LO) || (state == S_HI)))
      wcnt_nxt = wcnt + WW'(1);

    ready    = (state == S_DONE) | ((state == S_IDLE) & ~req);
    last_now = (wcnt == WLAST);

    wr_src   = (state == S_IDLE) ? MEM_W_EN             : wr_q;
    word_src = (state == S_IDLE) ? addr[SRAM_AW:2]      : word_q;
    wd_src   = (state == S_IDLE) ? wdata                : wd_q;

    act_nxt  = (state_nxt == S_LO) | (state_nxt == S_HI);
    hi_nxt   = (state_nxt == S_HI);
    last_nxt = (wcnt_nxt == WLAST);
  end

  // Pad-side outputs are registered from the next-state decode so the write
  // strobe is glitch-free and lines up exactly with the LO/HI cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      wr_q        <= 1'b0;
      word_q      <= '0;
      wd_q        <= '0;
      rdata       <= '0;
      SRAM_ADDR   <= '0;
      SRAM_WE_N   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;

      if ((state == S_IDLE) && req) begin
        wr_q   <= MEM_W_EN;
        word_q <= addr[SRAM_AW:2];
        wd_q   <= wdata;
      end

      // Strobe low for all but the last cycle of each half; the last cycle
      // keeps address and data on the bus as hold time.
      SRAM_WE_N  <= ~(wr_src & act_nxt & ~last_nxt);
      sram_dq_oe <= wr_src & act_nxt;
      if (act_nxt)
        SRAM_ADDR <= {word_src, hi_nxt};
      if (act_nxt && wr_src)
        sram_dq_out <= hi_nxt ? wd_src[31:16] : wd_src[15:0];

      if (!wr_q && last_now) begin
        if (state == S_LO)
          rdata[15:0] <= sram_dq_in;
        else if (state == S_HI)
          rdata[31:16] <= sram_dq_in;
      end
    end
  end

`ifdef SRAM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == S_DONE) begin
      if (wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

  localparam int N  = 3;          // clocks per half-word access (WAIT_CYCLES=2)
  localparam int DN = 2 * N + 1;  // cycle index of the completion cycle

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe;

  logic        b_r_en;
  logic [31:0] b_addr, b_rdata;
  logic        b_ready;
  logic [17:0] b_sram_addr;
  logic        b_we_n;
  logic [15:0] b_dq_out, b_dq_in;
  logic        b_dq_oe;

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] rd_count, wr_count, b_rd_count, b_wr_count;
`endif

  always #5 clk = ~clk;

  sram_mem_controller #(.SRAM_AW(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_dq_in(dq_in)
`ifdef SRAM_CTRL_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  sram_mem_controller #(.SRAM_AW(18), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(b_r_en), .MEM_W_EN(1'b0),
    .addr(b_addr), .wdata(32'h0), .rdata(b_rdata), .ready(b_ready),
    .SRAM_ADDR(b_sram_addr), .SRAM_WE_N(b_we_n), .sram_dq_out(b_dq_out),
    .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in)
`ifdef SRAM_CTRL_STATS_EN
    , .rd_count(b_rd_count), .wr_count(b_wr_count)
`endif
  );

  // SRAM pad model (low 8 half-word address bits are enough for the stimulus)
  logic [15:0] pad_mem [256];
  assign dq_in   = pad_mem[sram_addr[7:0]];
  assign b_dq_in = pad_mem[b_sram_addr[7:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_low = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: k is the index of the current cycle inside
  // a transaction (0 = idle, 1..N low half, N+1..2N high half, 2N+1 done).
  int          k = 0;
  bit          armed = 1'b0;
  bit          loaded = 1'b0;
  bit          m_wr;
  logic [16:0] m_word;
  logic [31:0] m_wd;
  logic [31:0] m_rdata = 32'h0;
  logic [15:0] ref_mem [256];
  int          m_rdc = 0, m_wrc = 0;

  function automatic logic [7:0] ridx(input logic [16:0] w, input bit hi);
    return {w[6:0], hi};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) begin
        logic [15:0] v;
        v = 16'(i * 40503 + 4660);
        if (i == 8) v = 16'h5678;
        if (i == 9) v = 16'h1234;
        pad_mem[i] <= v;
        ref_mem[i] = v;
      end
      loaded = 1'b1;
    end else if (!sram_we_n) begin
      pad_mem[sram_addr[7:0]] <= dq_out;
    end

    if (k >= 1 && k <= 2 * N && m_wr && k != N && k != 2 * N)
      ref_mem[ridx(m_word, k > N)] = (k > N) ? m_wd[31:16] : m_wd[15:0];

    if (!rst_n) begin
      k = 0; m_rdata = 32'h0; m_rdc = 0; m_wrc = 0; armed = 1'b1;
    end else if (k == 0) begin
      if (mem_r_en | mem_w_en) begin
        m_wr = mem_w_en; m_word = addr[18:2]; m_wd = wdata; k = 1;
      end
    end else if (k == DN) begin
      if (m_wr) begin if (m_wrc < 65535) m_wrc++; end
      else begin if (m_rdc < 65535) m_rdc++; end
      k = 0;
    end else begin
      if (!m_wr && k == N)     m_rdata[15:0]  = ref_mem[ridx(m_word, 1'b0)];
      if (!m_wr && k == 2 * N) m_rdata[31:16] = ref_mem[ridx(m_word, 1'b1)];
      k++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit act, hi, last, strobe;
      act    = (k >= 1) && (k <= 2 * N);
      hi     = (k > N);
      last   = (k == N) || (k == 2 * N);
      strobe = act && m_wr && !last;
      if (!sram_we_n) we_low++;
      chk("ready", 32'(ready), 32'((k == DN) || (k == 0 && !(mem_r_en | mem_w_en))));
      chk("we_n", 32'(sram_we_n), 32'(!strobe));
      if (strobe) chk("oe_on", 32'(dq_oe), 32'd1);
      if (!(act && m_wr)) chk("oe_off", 32'(dq_oe), 32'd0);
      if (act) chk("sram_addr", 32'(sram_addr), 32'({m_word, hi}));
      if (act && m_wr) chk("dq_out", 32'(dq_out), 32'(hi ? m_wd[31:16] : m_wd[15:0]));
      chk("rdata", rdata, m_rdata);
`ifdef SRAM_CTRL_STATS_EN
      chk("rd_count", 32'(rd_count), 32'(m_rdc));
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
`endif
    end
  end

  task automatic txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input int drop, input bit keep, output int lat, output int rc);
    mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
    lat = -1; rc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin lat = c; rc = cyc; break; end
      @(posedge clk); #1;
      if (drop > 0 && c + 1 == drop) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
    end
    #1;
    if (!keep) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
    @(posedge clk); #1;
    chk("latency", 32'(lat), 32'(DN));
  endtask

  initial begin
    int lat, rc1, rc2, w0, mism;
    logic [31:0] a, d;
    rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
    b_r_en = 1'b0; b_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq_out", 32'(dq_out), 32'h0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    w0 = we_low;
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0, lat, rc1);
    chk("t1_rdata", rdata, 32'h12345678);
    chk("t1_no_strobe", 32'(we_low - w0), 32'd0);

    b_r_en = 1'b1; b_addr = 32'h10; lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_ready) begin lat = c; break; end
      @(posedge clk); #1;
    end
    #1 b_r_en = 1'b0;
    chk("t6_latency", 32'(lat), 32'd3);
    chk("t6_rdata", b_rdata, 32'h12345678);
`ifdef SRAM_CTRL_STATS_EN
    chk("t6_rd_count", 32'(b_rd_count), 32'd1);
`endif
    @(posedge clk); #1;

    w0 = we_low;
    txn(1'b0, 1'b1, 32'h20, 32'hCAFEBABE, 0, 1'b0, lat, rc1);
    chk("t2_lo", 32'(pad_mem[8'h10]), 32'hBABE);
    chk("t2_hi", 32'(pad_mem[8'h11]), 32'hCAFE);
    chk("t2_strobes", 32'(we_low - w0), 32'd4);
    chk("t2_oe_after", 32'(dq_oe), 32'd0);

    txn(1'b0, 1'b1, 32'h20, 32'hCAFEBABE, 0, 1'b1, lat, rc1);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0, lat, rc2);
    chk("t3_gap", 32'(rc2 - rc1), 32'd8);
    chk("t3_rdata", rdata, 32'hCAFEBABE);
`ifdef SRAM_CTRL_STATS_EN
    chk("t3_rd_count", 32'(rd_count), 32'd2);
    chk("t3_wr_count", 32'(wr_count), 32'd2);
`endif

    txn(1'b1, 1'b1, 32'h30, 32'hDEADBEEF, 0, 1'b0, lat, rc1);
    chk("t5_rdata_kept", rdata, 32'hCAFEBABE);
    chk("t5_lo", 32'(pad_mem[8'h18]), 32'hBEEF);
    chk("t5_hi", 32'(pad_mem[8'h19]), 32'hDEAD);

    mem_w_en = 1'b1; addr = 32'h20; wdata = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_we_n", 32'(sram_we_n), 32'd1);
    chk("t4_oe", 32'(dq_oe), 32'd0);
    chk("t4_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    chk("t4_hi_kept", 32'(pad_mem[8'h11]), 32'hCAFE);
    chk("t4_lo_done", 32'(pad_mem[8'h10]), 32'h2222);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0, lat, rc1);
    chk("t4_read", rdata, 32'hCAFE2222);

    for (int i = 0; i < 80; i++) begin
      int op, drop;
      bit keep;
      op = $urandom_range(0, 3);
      a = $urandom();
      a[18:2] = 17'($urandom_range(0, 15));
      d = $urandom();
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      keep = ($urandom_range(0, 2) == 0);
      txn(op != 1, op == 1 || op == 2, a, d, drop, keep, lat, rc1);
      if (!keep) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (2) @(posedge clk);

    mism = 0;
    for (int i = 0; i < 256; i++) if (pad_mem[i] !== ref_mem[i]) mism++;
    chk("sram_contents", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
